// File: rtl/fp_pkg.sv
// fp_pkg: shared FP32 field constants, format/rounding codes, FSM states and saturation helpers
package fp_pkg;
  localparam int FP_EXP_W  = 8;
  localparam int FP_FRAC_W = 23;
  localparam int FP_BIAS   = 127;
  typedef enum logic [1:0] {
    FMT_W  = 2'b00,
    FMT_WU = 2'b01,
    FMT_L  = 2'b10,
    FMT_LU = 2'b11
  } fmt_e;
  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [63:0] SAT_MAX_W  = 64'h0000_0000_7FFF_FFFF;
  localparam logic [63:0] SAT_MAX_WU = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] SAT_MAX_L  = 64'h7FFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MAX_LU = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam logic [63:0] SAT_MIN_W  = 64'h0000_0000_8000_0000;
  localparam logic [63:0] SAT_MIN_L  = 64'h8000_0000_0000_0000;
  localparam logic [63:0] SAT_MIN_U  = 64'h0;
  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SHIFT,
    S_ROUND,
    S_OUT
  } state_e;
  function automatic logic [63:0] sat_max(input logic [1:0] fmt);
    return fmt == FMT_W ? SAT_MAX_W : fmt == FMT_WU ? SAT_MAX_WU : fmt == FMT_L ? SAT_MAX_L : SAT_MAX_LU;
  endfunction
  function automatic logic [63:0] sat_min(input logic [1:0] fmt);
    return fmt == FMT_W ? SAT_MIN_W : fmt == FMT_L ? SAT_MIN_L : SAT_MIN_U;
  endfunction
  // 32-bit formats are returned sign-extended from bit 31 in the 64-bit register
  function automatic logic [63:0] sext(input logic [1:0] fmt, input logic [63:0] v);
    return fmt[1] ? v : {{32{v[31]}}, v[31:0]};
  endfunction
endpackage

// File: rtl/fp2int_round.sv
// fp2int_round: rounds an aligned magnitude and checks it against the target integer range
//   mag/g/s  : aligned integer magnitude, guard and sticky bits
//   neg      : operand sign
//   rm, fmt  : rounding mode and target format
//   rmag     : rounded magnitude (low 64 bits)
//   range_ok : rounded value representable in fmt
//   nx       : inexact (only with FP2INT_FLAGS_EN)
module fp2int_round import fp_pkg::*; (
  input  logic [63:0] mag,
  input  logic        g,
  input  logic        s,
  input  logic        neg,
  input  logic [2:0]  rm,
  input  logic [1:0]  fmt,
  output logic [63:0] rmag,
  output logic        range_ok
`ifdef FP2INT_FLAGS_EN
  ,
  output logic        nx
`endif
);
  logic inc;
  logic [64:0] sum;
  logic [64:0] lim;
  assign inc = rm == RM_RNE ? g & (s | mag[0]) :
               rm == RM_RDN ? neg & (g | s) :
               rm == RM_RUP ? !neg & (g | s) :
               rm == RM_RMM ? g : 1'b0;
  assign sum = {1'b0, mag} + 65'(inc);
  // signed formats allow one extra step of magnitude on the negative side
  assign lim = fmt[0] ? (neg ? 65'd0 : fmt[1] ? {1'b0, {64{1'b1}}} : 65'h0_FFFF_FFFF) :
               (fmt[1] ? 65'h1 << 63 : 65'h1 << 31) - 65'(!neg);
  assign range_ok = sum <= lim;
  assign rmag = sum[63:0];
`ifdef FP2INT_FLAGS_EN
  assign nx = g | s;
`endif
endmodule

// File: rtl/fp_to_int_iter.sv
// fp_to_int_iter: multi-cycle FP32 -> s32/u32/s64/u64 converter with an iterative alignment shifter
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid/in_ready   : operand handshake; in_data (binary32), in_fmt, in_rm
//   out_valid/out_ready : result handshake; out_data (64-bit, 32-bit formats sign-extended)
//   out_nv/out_nx       : invalid/inexact flags, present only when FP2INT_FLAGS_EN is defined
module fp_to_int_iter import fp_pkg::*; #(
  parameter int SHIFT_STEP = 8
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic [1:0]  in_fmt,
  input  logic [2:0]  in_rm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data
`ifdef FP2INT_FLAGS_EN
  ,
  output logic        out_nv,
  output logic        out_nx
`endif
);
  localparam logic [6:0] STEP = 7'(SHIFT_STEP);
  state_e state;
  logic [31:0] data_q;
  logic [1:0] fmt_q;
  logic [2:0] rm_q;
  logic [63:0] mag;
  logic g, s, left;
  logic [6:0] rem;
  logic [7:0] ex;
  logic [22:0] fr;
  logic neg, nan, ovf;
  logic signed [9:0] e, nd;
  logic [6:0] shamt, n;
  logic [63:0] gbit, rmag, res, sat;
  logic range_ok;
`ifdef FP2INT_FLAGS_EN
  logic rnd_nx;
`endif
  assign ex = data_q[30:23];
  assign fr = data_q[22:0];
  assign neg = data_q[31];
  assign e = ex == 8'd0 ? -10'sd126 : $signed({2'b00, ex}) - 10'sd127;
  assign nan = ex == 8'hFF && fr != 23'd0;
  // any L value with e==63 overflows except exactly -2^63, so catch it before shifting
  assign ovf = ex == 8'hFF || e >= 10'sd64 ||
               (fmt_q == FMT_L && e == 10'sd63 && !(neg && fr == 23'd0));
  assign nd = 10'sd23 - e;
  // right shifts cap at 26: beyond that everything is already sticky and guard is zero
  assign shamt = e >= 10'sd23 ? 7'(e - 10'sd23) : nd > 10'sd26 ? 7'd26 : 7'(nd);
  assign n = rem > STEP ? STEP : rem;
  assign gbit = 64'd1 << (n - 7'd1);
  assign sat = sext(fmt_q, (nan || !neg) ? sat_max(fmt_q) : sat_min(fmt_q));
  assign res = neg ? -rmag : rmag;
  fp2int_round u_round (
    .mag      (mag),
    .g        (g),
    .s        (s),
    .neg      (neg),
    .rm       (rm_q),
    .fmt      (fmt_q),
    .rmag     (rmag),
    .range_ok (range_ok)
`ifdef FP2INT_FLAGS_EN
    ,
    .nx       (rnd_nx)
`endif
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= 64'd0;
      data_q    <= 32'd0;
      fmt_q     <= 2'd0;
      rm_q      <= 3'd0;
      mag       <= 64'd0;
      g         <= 1'b0;
      s         <= 1'b0;
      left      <= 1'b0;
      rem       <= 7'd0;
`ifdef FP2INT_FLAGS_EN
      out_nv    <= 1'b0;
      out_nx    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          data_q   <= in_data;
          fmt_q    <= in_fmt;
          rm_q     <= in_rm;
          in_ready <= 1'b0;
          state    <= S_DECODE;
        end
        S_DECODE: if (ovf) begin
          out_data  <= sat;
          out_valid <= 1'b1;
          state     <= S_OUT;
`ifdef FP2INT_FLAGS_EN
          out_nv    <= 1'b1;
          out_nx    <= 1'b0;
`endif
        end else begin
          mag   <= {40'd0, ex != 8'd0, fr};
          g     <= 1'b0;
          s     <= 1'b0;
          left  <= e >= 10'sd23;
          rem   <= shamt;
          state <= shamt == 7'd0 ? S_ROUND : S_SHIFT;
        end
        S_SHIFT: begin
          mag <= left ? mag << n : mag >> n;
          // on right shifts the last bit out becomes guard; earlier guard folds into sticky
          if (!left) begin
            g <= |(mag & gbit);
            s <= s | g | |(mag & (gbit - 64'd1));
          end
          rem <= rem - n;
          if (rem == n) state <= S_ROUND;
        end
        S_ROUND: begin
          out_data  <= range_ok ? sext(fmt_q, res) : sat;
          out_valid <= 1'b1;
          state     <= S_OUT;
`ifdef FP2INT_FLAGS_EN
          out_nv    <= !range_ok;
          out_nx    <= range_ok & rnd_nx;
`endif
        end
        S_OUT: if (out_ready) begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fp_to_int_iter.sv
// tb_fp_to_int_iter: scoreboard bench for fp_to_int_iter (SHIFT_STEP=8); flags checked when FP2INT_FLAGS_EN is defined
module tb_fp_to_int_iter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_data = 32'd0;
  logic [1:0] in_fmt = 2'd0;
  logic [2:0] in_rm = 3'd0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [63:0] out_data;
`ifdef FP2INT_FLAGS_EN
  logic out_nv, out_nx;
`endif
  typedef struct {
    logic [63:0] data;
    logic        nv;
    logic        nx;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  fp_to_int_iter #(.SHIFT_STEP(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_fmt    (in_fmt),
    .in_rm     (in_rm),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef FP2INT_FLAGS_EN
    ,
    .out_nv    (out_nv),
    .out_nx    (out_nx)
`endif
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  // latency counts the acceptance cycle as 0 and the first out_valid cycle as the result
  task automatic run(input string nm, input logic [31:0] d, input logic [1:0] f, input logic [2:0] r,
                     input logic [63:0] xd, input logic xnv, input logic xnx, input int xl);
    exp_t x;
    int lat, w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1;
      w++;
    end
    check({nm, " in_ready"}, 64'(in_ready), 64'd1);
    sb.push_back('{xd, xnv, xnx, xl});
    in_data = d;
    in_fmt = f;
    in_rm = r;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data = ~d;
    in_fmt = ~f;
    in_rm = ~r;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    x = sb.pop_front();
    check({nm, " latency"}, 64'(lat), 64'(x.lat));
    check({nm, " data"}, out_data, x.data);
    check({nm, " busy"}, 64'(in_ready), 64'd0);
`ifdef FP2INT_FLAGS_EN
    check({nm, " nv"}, 64'(out_nv), 64'(x.nv));
    check({nm, " nx"}, 64'(out_nx), 64'(x.nx));
`endif
    if (out_ready) begin
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [63:0] held;
    repeat (2) @(posedge clk);
    #1;
    check("rst out_valid", 64'(out_valid), 64'd0);
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_data", out_data, 64'd0);
`ifdef FP2INT_FLAGS_EN
    check("rst flags", {62'd0, out_nv, out_nx}, 64'd0);
`endif
    rst_n = 1'b1;
    @(posedge clk); #1;
    run("pi",      32'h40490FDB, 2'b00, 3'd0, 64'h0000000000000003, 1'b0, 1'b1, 6);
    run("m2.5rne", 32'hC0200000, 2'b10, 3'd0, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 6);
    run("m2.5rmm", 32'hC0200000, 2'b10, 3'd4, 64'hFFFFFFFFFFFFFFFD, 1'b0, 1'b1, 6);
    run("m2.5rup", 32'hC0200000, 2'b10, 3'd3, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 6);
    run("nan_w",   32'h7FC00000, 2'b00, 3'd0, 64'h000000007FFFFFFF, 1'b1, 1'b0, 2);
    run("nan_wu",  32'h7FC00000, 2'b01, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 2);
    run("ninf_l",  32'hFF800000, 2'b10, 3'd0, 64'h8000000000000000, 1'b1, 1'b0, 2);
    run("p2e63_l", 32'h5F000000, 2'b10, 3'd0, 64'h7FFFFFFFFFFFFFFF, 1'b1, 1'b0, 2);
    run("p2e63_lu",32'h5F000000, 2'b11, 3'd0, 64'h8000000000000000, 1'b0, 1'b0, 8);
    run("mhalfrdn",32'hBF000000, 2'b01, 3'd2, 64'h0000000000000000, 1'b1, 1'b0, 6);
    run("mhalfrtz",32'hBF000000, 2'b01, 3'd1, 64'h0000000000000000, 1'b0, 1'b1, 6);
    run("p2e31_wu",32'h4F000000, 2'b01, 3'd0, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 4);
    run("mzero",   32'h80000000, 2'b00, 3'd0, 64'h0000000000000000, 1'b0, 1'b0, 7);
    run("m2e63_l", 32'hDF000000, 2'b10, 3'd0, 64'h8000000000000000, 1'b0, 1'b0, 8);
    run("1.5rne",  32'h3FC00000, 2'b00, 3'd0, 64'h0000000000000002, 1'b0, 1'b1, 6);
    run("2.5rne",  32'h40200000, 2'b00, 3'd0, 64'h0000000000000002, 1'b0, 1'b1, 6);
    run("one_lu",  32'h3F800000, 2'b11, 3'd0, 64'h0000000000000001, 1'b0, 1'b0, 6);
    run("p2e23",   32'h4B000000, 2'b00, 3'd0, 64'h0000000000800000, 1'b0, 1'b0, 3);
    run("p2e31_w", 32'h4F000000, 2'b00, 3'd0, 64'h000000007FFFFFFF, 1'b1, 1'b0, 4);
    run("m2e31_w", 32'hCF000000, 2'b00, 3'd0, 64'hFFFFFFFF80000000, 1'b0, 1'b0, 4);
    run("m1.5rdn", 32'hBFC00000, 2'b00, 3'd2, 64'hFFFFFFFFFFFFFFFE, 1'b0, 1'b1, 6);
    run("pinf_lu", 32'h7F800000, 2'b11, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 2);
    run("p2e32_wu",32'h4F800000, 2'b01, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 5);
    run("p2e64_lu",32'h5F800000, 2'b11, 3'd0, 64'hFFFFFFFFFFFFFFFF, 1'b1, 1'b0, 2);
    run("denormup",32'h00000001, 2'b00, 3'd3, 64'h0000000000000001, 1'b0, 1'b1, 7);
    out_ready = 1'b0;
    run("stall",   32'h40490FDB, 2'b10, 3'd0, 64'h0000000000000003, 1'b0, 1'b1, 6);
    held = out_data;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("stall valid", 64'(out_valid), 64'd1);
      check("stall data", out_data, held);
      check("stall in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("drain valid", 64'(out_valid), 64'd0);
    check("drain in_ready", 64'(in_ready), 64'd1);
    in_data = 32'h5F000000;
    in_fmt = 2'b11;
    in_rm = 3'd0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst valid", 64'(out_valid), 64'd0);
    check("midrst in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("postrst valid", 64'(out_valid), 64'd0);
    check("postrst in_ready", 64'(in_ready), 64'd1);
    check("postrst data", out_data, 64'd0);
    run("recover", 32'h3F800000, 2'b00, 3'd0, 64'h0000000000000001, 1'b0, 1'b0, 6);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
